// File: rtl/dac_volume_ramp.sv
// -----------------------------------------------------------------------------
// dac_volume_ramp
//
// Soft volume ramp controller that sits in front of the PCM1780 control-bus
// serializer. A CSR supplies a target volume and a mute level. The block walks
// the applied DAC volume toward the effective target one step at a time, so
// large jumps never reach the DAC as audible zipper noise. Each applied step
// is handed to the serializer as a one-cycle strobe plus the new 8-bit volume.
// Strobes are spaced STEP_CYCLES apart, which is long enough for a full serial
// control frame to complete before the next one starts.
//
// After reset the block first issues one strobe at volume 0x00. This puts the
// DAC back in step with the internal state, whatever the DAC held before.
//
// Ports
//   i_clk48         in   1  system clock (48 MHz), sole clock
//   i_rst48         in   1  synchronous active-high reset
//   i_target_valid  in   1  one-cycle pulse: capture i_target
//   i_target        in   8  requested volume (0x00 min .. 0xFF max)
//   i_mute          in   1  level; forces the effective target to 0x00
//   o_valid         out  1  one-cycle strobe to the serializer
//   o_volume        out  8  currently applied volume (always valid)
//   o_busy          out  1  high while resyncing or not yet at the target
// -----------------------------------------------------------------------------
module dac_volume_ramp #(
    parameter int unsigned STEP_CYCLES = 48000,
    parameter int unsigned STEP_SIZE   = 1
) (
    input  logic       i_clk48,
    input  logic       i_rst48,
    input  logic       i_target_valid,
    input  logic [7:0] i_target,
    input  logic       i_mute,
    output logic       o_valid,
    output logic [7:0] o_volume,
    output logic       o_busy
);

    // Reject parameter values that would break frame spacing or the step math.
    generate
        if (STEP_CYCLES < 320) begin : g_bad_step_cycles_low
            $error("dac_volume_ramp: STEP_CYCLES must be >= 320");
        end
        if (STEP_CYCLES > 1048575) begin : g_bad_step_cycles_high
            $error("dac_volume_ramp: STEP_CYCLES must fit in 20 bits");
        end
        if ((STEP_SIZE < 1) || (STEP_SIZE > 255)) begin : g_bad_step_size
            $error("dac_volume_ramp: STEP_SIZE must be 1..255");
        end
    endgenerate

    localparam logic [19:0] TIMER_RELOAD = 20'(STEP_CYCLES - 1);
    localparam logic [8:0]  STEP9        = 9'(STEP_SIZE);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  tgt_q,   tgt_d;
    logic [7:0]  cur_q,   cur_d;
    logic [19:0] timer_q, timer_d;
    logic        valid_q, valid_d;

    logic [7:0]  eff;
    logic        timer_zero;
    logic        strobe;
    logic [8:0]  up_gap;
    logic [8:0]  dn_gap;
    logic [8:0]  up_step;
    logic [8:0]  dn_step;
    logic [8:0]  cur_up9;
    logic [8:0]  cur_dn9;

    // Mute acts combinationally, so it is seen in the same cycle it changes.
    assign eff        = i_mute ? 8'h00 : tgt_q;
    assign timer_zero = (timer_q == 20'd0);

    // 9-bit distance to the target in each direction. Only the one that
    // matches the actual direction is used. Clamping the step to that
    // distance keeps cur from overshooting eff and from wrapping.
    assign up_gap  = {1'b0, eff}   - {1'b0, cur_q};
    assign dn_gap  = {1'b0, cur_q} - {1'b0, eff};
    assign up_step = (up_gap < STEP9) ? up_gap : STEP9;
    assign dn_step = (dn_gap < STEP9) ? dn_gap : STEP9;
    assign cur_up9 = {1'b0, cur_q} + up_step;
    assign cur_dn9 = {1'b0, cur_q} - dn_step;

    // Next-state and strobe decision.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        strobe  = 1'b0;
        // A target write is always accepted, even mid-ramp. The ramp logic
        // then simply chases the new value from the next cycle on.
        tgt_d   = i_target_valid ? i_target : tgt_q;

        case (state_q)
            ST_INIT: begin
                // Resync strobe: re-send the current (reset) volume once.
                if (timer_zero) begin
                    strobe  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Only arm the ramp here. The first step happens from RAMP,
                // so the step timing is the same for every entry path.
                if (cur_q != eff) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (cur_q == eff) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    strobe = 1'b1;
                    if (eff > cur_q) begin
                        cur_d = cur_up9[7:0];
                    end else begin
                        cur_d = cur_dn9[7:0];
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // The spacing timer restarts on every strobe and then runs down to 0.
        // A later ramp request therefore still waits out the remaining time.
        if (strobe) begin
            timer_d = TIMER_RELOAD;
        end else if (!timer_zero) begin
            timer_d = timer_q - 20'd1;
        end else begin
            timer_d = 20'd0;
        end

        valid_d = strobe;
    end

    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            state_q <= ST_INIT;
            tgt_q   <= 8'h00;
            cur_q   <= 8'h00;
            timer_q <= 20'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_volume = cur_q;
    assign o_busy   = (state_q == ST_INIT) | (cur_q != eff);

endmodule
